// File: rtl/hazard_controller.sv
// Load-use stall / branch flush / halt sequencer for the 5-stage core.
// Optional HAZARD_STATS_EN adds saturating stall_count / flush_count outputs.
module hazard_controller #(
  parameter int ADDR_W            = 3,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_addr_p2_A,
  input  logic [ADDR_W-1:0] read_addr_p2_B,
  input  logic              use_A_p2,
  input  logic              use_B_p2,
  input  logic [ADDR_W-1:0] write_addr_p3,
  input  logic              mem_read_p3,
  input  logic              branch_taken_p3,
  input  logic              halt_p3,
  output logic              stall_p1,
  output logic              stall_p2,
  output logic              bubble_p3,
  output logic              flush_p1,
  output logic              flush_p2,
  output logic              halted
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic [1:0] {S_RUN, S_LSTALL, S_HALT} state_t;

  localparam logic [2:0] LSC_M1 = 3'(LOAD_STALL_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_rst_d;
  logic       w_hazard;
  logic       w_active;

  assign w_hazard = mem_read_p3 &
                    ((use_A_p2 & (read_addr_p2_A == write_addr_p3)) |
                     (use_B_p2 & (read_addr_p2_B == write_addr_p3)));

  // Outputs and transitions are suppressed in the reset cycle and the one after it.
  assign w_active = !reset && !r_rst_d;

  always_comb begin
    stall_p1  = 1'b0;
    stall_p2  = 1'b0;
    bubble_p3 = 1'b0;
    flush_p1  = 1'b0;
    flush_p2  = 1'b0;
    halted    = 1'b0;
    if (w_active) begin
      case (r_state)
        S_RUN: begin
          if (halt_p3) begin
            flush_p1 = 1'b1;
            flush_p2 = 1'b1;
            stall_p1 = 1'b1;
          end else if (branch_taken_p3) begin
            flush_p1 = 1'b1;
            flush_p2 = 1'b1;
          end else if (w_hazard) begin
            stall_p1  = 1'b1;
            stall_p2  = 1'b1;
            bubble_p3 = 1'b1;
          end
        end
        S_LSTALL: begin
          stall_p1  = 1'b1;
          stall_p2  = 1'b1;
          bubble_p3 = 1'b1;
        end
        S_HALT: begin
          stall_p1  = 1'b1;
          stall_p2  = 1'b1;
          bubble_p3 = 1'b1;
          halted    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
      r_rst_d <= 1'b1;
    end else begin
      r_rst_d <= 1'b0;
      if (!r_rst_d) begin
        case (r_state)
          S_RUN: begin
            if (halt_p3) begin
              r_state <= S_HALT;
            end else if (branch_taken_p3) begin
              r_state <= S_RUN;
            end else if (w_hazard && (LOAD_STALL_CYCLES > 1)) begin
              r_cnt   <= LSC_M1;
              r_state <= S_LSTALL;
            end
          end
          S_LSTALL: begin
            // Branch/halt in p3 are ignored here: p3 holds a bubble.
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) r_state <= S_RUN;
          end
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic w_branch_flush;
  assign w_branch_flush = w_active && (r_state == S_RUN) && !halt_p3 && branch_taken_p3;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (bubble_p3 && (r_state != S_HALT) && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (w_branch_flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: three instances (LOAD_STALL_CYCLES 1/3/4)
// share stimulus; per-cycle expectations go through a scoreboard queue.
module tb_hazard_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] ra, rb, wa;
  logic       ua, ub, mr, br, ht;

  // {stall_p1, stall_p2, bubble_p3, flush_p1, flush_p2, halted}
  wire [5:0] o1, o3, o4;

  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] STALL  = 6'b111000;
  localparam logic [5:0] FLUSH  = 6'b000110;
  localparam logic [5:0] HENTRY = 6'b100110;
  localparam logic [5:0] HALTD  = 6'b111001;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         id;
    logic [5:0] exp;
  } exp_t;
  exp_t sb[$];

`ifdef HAZARD_STATS_EN
  wire [15:0] sc1, fc1, sc3, fc3, sc4, fc4;
`endif

  always #5 clock = ~clock;

  hazard_controller #(.ADDR_W(3), .LOAD_STALL_CYCLES(1)) d1 (
    .clock(clock), .reset(reset),
    .read_addr_p2_A(ra), .read_addr_p2_B(rb), .use_A_p2(ua), .use_B_p2(ub),
    .write_addr_p3(wa), .mem_read_p3(mr), .branch_taken_p3(br), .halt_p3(ht),
    .stall_p1(o1[5]), .stall_p2(o1[4]), .bubble_p3(o1[3]),
    .flush_p1(o1[2]), .flush_p2(o1[1]), .halted(o1[0])
`ifdef HAZARD_STATS_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  hazard_controller #(.ADDR_W(3), .LOAD_STALL_CYCLES(3)) d3 (
    .clock(clock), .reset(reset),
    .read_addr_p2_A(ra), .read_addr_p2_B(rb), .use_A_p2(ua), .use_B_p2(ub),
    .write_addr_p3(wa), .mem_read_p3(mr), .branch_taken_p3(br), .halt_p3(ht),
    .stall_p1(o3[5]), .stall_p2(o3[4]), .bubble_p3(o3[3]),
    .flush_p1(o3[2]), .flush_p2(o3[1]), .halted(o3[0])
`ifdef HAZARD_STATS_EN
    , .stall_count(sc3), .flush_count(fc3)
`endif
  );

  hazard_controller #(.ADDR_W(3), .LOAD_STALL_CYCLES(4)) d4 (
    .clock(clock), .reset(reset),
    .read_addr_p2_A(ra), .read_addr_p2_B(rb), .use_A_p2(ua), .use_B_p2(ub),
    .write_addr_p3(wa), .mem_read_p3(mr), .branch_taken_p3(br), .halt_p3(ht),
    .stall_p1(o4[5]), .stall_p2(o4[4]), .bubble_p3(o4[3]),
    .flush_p1(o4[2]), .flush_p2(o4[1]), .halted(o4[0])
`ifdef HAZARD_STATS_EN
    , .stall_count(sc4), .flush_count(fc4)
`endif
  );

  task automatic drv(input logic rst, input logic a_use, input logic [2:0] a,
                     input logic b_use, input logic [2:0] b, input logic ld,
                     input logic [2:0] w, input logic brn, input logic hlt);
    reset = rst; ua = a_use; ra = a; ub = b_use; rb = b;
    mr = ld; wa = w; br = brn; ht = hlt;
  endtask

  task automatic idle(input logic rst);
    drv(rst, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Push expectations for the cycle just driven, sample mid-cycle, then advance.
  task automatic chk(input string tag, input logic [5:0] e1, input logic [5:0] e3,
                     input logic [5:0] e4);
    exp_t       e;
    logic [5:0] obs;
    sb.push_back('{tag, 1, e1});
    sb.push_back('{tag, 3, e3});
    sb.push_back('{tag, 4, e4});
    @(negedge clock);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = (e.id == 1) ? o1 : (e.id == 3) ? o3 : o4;
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s lsc%0d observed=%b expected=%b", e.tag, e.id, obs, e.exp);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    idle(1'b1);
    @(posedge clock);
    #1;
    // Hazard presented during reset and in the masked cycle after it
    drv(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0);
    chk("reset", NONE, NONE, NONE);
    drv(1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0);
    chk("post_reset", NONE, NONE, NONE);

    // Load-use on A, load advances the next cycle
    chk("hazA", STALL, STALL, STALL);
    idle(1'b0);
    chk("lstall_a", NONE, STALL, STALL);
    chk("lstall_b", NONE, STALL, STALL);
    chk("lstall_c", NONE, NONE, STALL);
    chk("lstall_d", NONE, NONE, NONE);

    // Non-hazards
    drv(1'b0, 1'b1, 3'd1, 1'b0, 3'd5, 1'b1, 3'd5, 1'b0, 1'b0);
    chk("b_unused", NONE, NONE, NONE);
    drv(1'b0, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0);
    chk("no_load", NONE, NONE, NONE);

    // Register 0 hazard via B, then branch arrives while in LSTALL
    drv(1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("hazB_r0", STALL, STALL, STALL);
    drv(1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("br_in_lstall", FLUSH, STALL, STALL);
    idle(1'b0);
    chk("br_lstall_a", NONE, STALL, STALL);
    chk("br_lstall_b", NONE, NONE, STALL);
    chk("br_lstall_c", NONE, NONE, NONE);

    // Branch beats hazard in RUN; counters checked from a clean reset
    idle(1'b1);
    chk("rst2", NONE, NONE, NONE);
    idle(1'b0);
    chk("rst2_post", NONE, NONE, NONE);
    drv(1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0);
    chk("br_hz", FLUSH, FLUSH, FLUSH);
    idle(1'b0);
    chk("br_after", NONE, NONE, NONE);
`ifdef HAZARD_STATS_EN
    chk16("flush_cnt1", fc1, 16'd1);
    chk16("flush_cnt4", fc4, 16'd1);
    chk16("stall_cnt_br", sc4, 16'd0);
`endif

    // Reset in the 2nd LSTALL cycle
    drv(1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 1'b0);
    chk("hz6", STALL, STALL, STALL);
    idle(1'b0);
    chk("ls6_1", NONE, STALL, STALL);
    idle(1'b1);
    chk("ls6_rst", NONE, NONE, NONE);
`ifdef HAZARD_STATS_EN
    chk16("stall_cnt4_stop", sc4, 16'd0);
`endif
    idle(1'b0);
    chk("ls6_post", NONE, NONE, NONE);
    chk("ls6_run", NONE, NONE, NONE);

    // Halt: flush pulse, then frozen for 100 cycles regardless of inputs
    drv(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("halt_entry", HENTRY, HENTRY, HENTRY);
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) drv(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
      else if (i % 3 == 1) drv(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      else idle(1'b0);
      chk("halted", HALTD, HALTD, HALTD);
    end
`ifdef HAZARD_STATS_EN
    chk16("stall_cnt_halt", sc4, 16'd0);
    chk16("flush_cnt_halt", fc1, 16'd0);
`endif
    idle(1'b1);
    chk("halt_rst", NONE, NONE, NONE);
    idle(1'b0);
    chk("halt_post", NONE, NONE, NONE);
    chk("halt_run", NONE, NONE, NONE);
    drv(1'b0, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 3'd7, 1'b0, 1'b0);
    chk("hz_after_halt", STALL, STALL, STALL);
    idle(1'b0);
    chk("final", NONE, STALL, STALL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
